// File: rtl/control_pkg.sv
// Shared decode types, opcode constants and operand-usage helpers for the RV32I decode stage.
package control_pkg;

  typedef enum logic [5:0] {
    CU_NOP = 6'd0,
    CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
    CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
    CU_SB, CU_SH, CU_SW,
    CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI,
    CU_SLLI, CU_SRLI, CU_SRAI,
    CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
    CU_ILLEGAL
  } cuop_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } aluop_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Unknown opcodes are treated as reading rs1 so hazard detection stays conservative.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_OP || opcode == OPC_BRANCH || opcode == OPC_STORE);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    return (opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL ||
            opcode == OPC_JALR || opcode == OPC_LOAD || opcode == OPC_OPIMM ||
            opcode == OPC_OP);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I instruction decoder: raw instruction in, control fields and immediate out.
module instr_decoder
  import control_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int REG_W = $clog2(NREGS)
) (
  input  logic [31:0]      instr,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd,
  output cuop_t            cuop,
  output aluop_t           aluop,
  output logic             reg_write,
  output logic             alu_src,
  output logic             is_load,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);

  localparam logic [5:0] NregsL = 6'(NREGS);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  cuop_t       base_cuop;
  aluop_t      base_aluop;
  logic        base_src;
  logic        base_load;
  logic [31:0] base_imm;
  logic        bad_reg;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Register fields pass through raw; narrower register files keep only the low bits.
  assign rs1 = instr[15 +: REG_W];
  assign rs2 = instr[20 +: REG_W];
  assign rd  = instr[7 +: REG_W];

  // Opcode/funct decode; anything not matched stays CU_ILLEGAL.
  always_comb begin
    base_cuop  = CU_ILLEGAL;
    base_aluop = ALU_ADD;
    base_src   = 1'b0;
    base_load  = 1'b0;
    base_imm   = '0;
    case (opcode)
      OPC_LUI: begin
        base_cuop = CU_LUI; base_aluop = ALU_PASSB; base_src = 1'b1; base_imm = imm_u;
      end
      OPC_AUIPC: begin
        base_cuop = CU_AUIPC; base_src = 1'b1; base_imm = imm_u;
      end
      OPC_JAL: begin
        base_cuop = CU_JAL; base_src = 1'b1; base_imm = imm_j;
      end
      OPC_JALR: begin
        base_src = 1'b1; base_imm = imm_i;
        if (funct3 == 3'd0) base_cuop = CU_JALR;
      end
      OPC_BRANCH: begin
        base_imm = imm_b;
        case (funct3)
          3'd0: begin base_cuop = CU_BEQ;  base_aluop = ALU_SUB;  end
          3'd1: begin base_cuop = CU_BNE;  base_aluop = ALU_SUB;  end
          3'd4: begin base_cuop = CU_BLT;  base_aluop = ALU_SLT;  end
          3'd5: begin base_cuop = CU_BGE;  base_aluop = ALU_SLT;  end
          3'd6: begin base_cuop = CU_BLTU; base_aluop = ALU_SLTU; end
          3'd7: begin base_cuop = CU_BGEU; base_aluop = ALU_SLTU; end
          default: ;
        endcase
      end
      OPC_LOAD: begin
        base_src = 1'b1; base_load = 1'b1; base_imm = imm_i;
        case (funct3)
          3'd0: base_cuop = CU_LB;
          3'd1: base_cuop = CU_LH;
          3'd2: base_cuop = CU_LW;
          3'd4: base_cuop = CU_LBU;
          3'd5: base_cuop = CU_LHU;
          default: ;
        endcase
      end
      OPC_STORE: begin
        base_src = 1'b1; base_imm = imm_s;
        case (funct3)
          3'd0: base_cuop = CU_SB;
          3'd1: base_cuop = CU_SH;
          3'd2: base_cuop = CU_SW;
          default: ;
        endcase
      end
      OPC_OPIMM: begin
        base_src = 1'b1; base_imm = imm_i;
        case (funct3)
          3'd0: begin base_cuop = CU_ADDI;  base_aluop = ALU_ADD;  end
          3'd2: begin base_cuop = CU_SLTI;  base_aluop = ALU_SLT;  end
          3'd3: begin base_cuop = CU_SLTIU; base_aluop = ALU_SLTU; end
          3'd4: begin base_cuop = CU_XORI;  base_aluop = ALU_XOR;  end
          3'd6: begin base_cuop = CU_ORI;   base_aluop = ALU_OR;   end
          3'd7: begin base_cuop = CU_ANDI;  base_aluop = ALU_AND;  end
          3'd1: if (funct7 == 7'h00) begin base_cuop = CU_SLLI; base_aluop = ALU_SLL; end
          3'd5: begin
            if (funct7 == 7'h00) begin
              base_cuop = CU_SRLI; base_aluop = ALU_SRL;
            end else if (funct7 == 7'h20) begin
              base_cuop = CU_SRAI; base_aluop = ALU_SRA;
            end
          end
          default: ;
        endcase
      end
      OPC_OP: begin
        case ({funct7, funct3})
          {7'h00, 3'd0}: begin base_cuop = CU_ADD;  base_aluop = ALU_ADD;  end
          {7'h20, 3'd0}: begin base_cuop = CU_SUB;  base_aluop = ALU_SUB;  end
          {7'h00, 3'd1}: begin base_cuop = CU_SLL;  base_aluop = ALU_SLL;  end
          {7'h00, 3'd2}: begin base_cuop = CU_SLT;  base_aluop = ALU_SLT;  end
          {7'h00, 3'd3}: begin base_cuop = CU_SLTU; base_aluop = ALU_SLTU; end
          {7'h00, 3'd4}: begin base_cuop = CU_XOR;  base_aluop = ALU_XOR;  end
          {7'h00, 3'd5}: begin base_cuop = CU_SRL;  base_aluop = ALU_SRL;  end
          {7'h20, 3'd5}: begin base_cuop = CU_SRA;  base_aluop = ALU_SRA;  end
          {7'h00, 3'd6}: begin base_cuop = CU_OR;   base_aluop = ALU_OR;   end
          {7'h00, 3'd7}: begin base_cuop = CU_AND;  base_aluop = ALU_AND;  end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Final fields: an illegal decode or an out-of-range register index forces a safe, inert op.
  always_comb begin
    bad_reg = (writes_rd(opcode) && ({1'b0, instr[11:7]}  >= NregsL)) ||
              (uses_rs1(opcode)  && ({1'b0, instr[19:15]} >= NregsL)) ||
              (uses_rs2(opcode)  && ({1'b0, instr[24:20]} >= NregsL));
    illegal   = (base_cuop == CU_ILLEGAL) || bad_reg;
    cuop      = base_cuop;
    aluop     = base_aluop;
    alu_src   = base_src;
    is_load   = base_load;
    imm       = XLEN'($signed(base_imm));
    reg_write = writes_rd(opcode) && (instr[11:7] != 5'd0);
    if (illegal) begin
      cuop      = CU_ILLEGAL;
      aluop     = ALU_ADD;
      alu_src   = 1'b0;
      is_load   = 1'b0;
      imm       = '0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage: one-entry output register, load-use bubble, flush,
// and a saturating hazard-stall counter.
module decode_stage
  import control_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16,
  localparam int REG_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [REG_W-1:0] out_rs1,
  output logic [REG_W-1:0] out_rs2,
  output logic [REG_W-1:0] out_rd,
  output cuop_t            out_cuOp,
  output aluop_t           out_aluOp,
  output logic             out_regWrite,
  output logic             out_aluSrc,
  output logic             out_isLoad,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {StEmpty, StFull} state_t;

  state_t state_q, state_d;

  logic [REG_W-1:0] dec_rs1, dec_rs2, dec_rd;
  cuop_t            dec_cuop;
  aluop_t           dec_aluop;
  logic             dec_reg_write, dec_alu_src, dec_is_load, dec_illegal;
  logic [XLEN-1:0]  dec_imm;

  logic             hazard, capture, handoff;
  logic [CNT_W-1:0] stall_d;

  instr_decoder #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_dec (
    .instr     (in_instr),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .rd        (dec_rd),
    .cuop      (dec_cuop),
    .aluop     (dec_aluop),
    .reg_write (dec_reg_write),
    .alu_src   (dec_alu_src),
    .is_load   (dec_is_load),
    .imm       (dec_imm),
    .illegal   (dec_illegal)
  );

  assign out_valid = (state_q == StFull);

  // Load-use hazard: the held load's result is not yet available to the offered instruction.
  always_comb begin
    hazard = out_valid && out_isLoad && (out_rd != '0) && in_valid &&
             ((uses_rs1(in_instr[6:0]) && (dec_rs1 == out_rd)) ||
              (uses_rs2(in_instr[6:0]) && (dec_rs2 == out_rd)));
    in_ready = (!out_valid || out_ready) && !hazard && !flush;
    capture  = in_valid && in_ready;
    handoff  = out_valid && out_ready;
  end

  // Next state: flush wins, then capture (possibly with a handoff), then plain handoff.
  always_comb begin
    state_d = state_q;
    if (flush)        state_d = StEmpty;
    else if (capture) state_d = StFull;
    else if (handoff) state_d = StEmpty;
  end

  // Stall counter next value, saturating at all-ones.
  always_comb begin
    stall_d = stall_cnt;
    if (in_valid && hazard && !flush && (stall_cnt != '1)) stall_d = stall_cnt + CNT_W'(1);
  end

  // State and stall counter registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StEmpty;
      stall_cnt <= '0;
    end else begin
      state_q   <= state_d;
      stall_cnt <= stall_d;
    end
  end

  // Output payload register; held unchanged unless a new instruction is captured.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      out_pc       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_cuOp     <= CU_NOP;
      out_aluOp    <= ALU_ADD;
      out_regWrite <= 1'b0;
      out_aluSrc   <= 1'b0;
      out_isLoad   <= 1'b0;
      out_imm      <= '0;
      out_illegal  <= 1'b0;
    end else if (capture) begin
      out_pc       <= in_pc;
      out_rs1      <= dec_rs1;
      out_rs2      <= dec_rs2;
      out_rd       <= dec_rd;
      out_cuOp     <= dec_cuop;
      out_aluOp    <= dec_aluop;
      out_regWrite <= dec_reg_write;
      out_aluSrc   <= dec_alu_src;
      out_isLoad   <= dec_is_load;
      out_imm      <= dec_imm;
      out_illegal  <= dec_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a
// table-driven reference model.
module tb_decode_stage;
  import control_pkg::*;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  logic        in_ready, out_valid, out_regWrite, out_aluSrc, out_isLoad, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [5:0]  out_cuOp;
  logic [3:0]  out_aluOp;
  logic [15:0] stall_cnt;

  logic        e_in_ready, e_out_valid, e_out_regWrite, e_out_aluSrc, e_out_isLoad, e_out_illegal;
  logic [31:0] e_out_pc, e_out_imm;
  logic [3:0]  e_out_rs1, e_out_rs2, e_out_rd;
  logic [5:0]  e_out_cuOp;
  logic [3:0]  e_out_aluOp;
  logic [2:0]  e_stall_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREGS(32), .CNT_W(16)) dut (
    .clk(clk), .nRst(nRst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_cuOp(out_cuOp), .out_aluOp(out_aluOp), .out_regWrite(out_regWrite),
    .out_aluSrc(out_aluSrc), .out_isLoad(out_isLoad), .out_imm(out_imm),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  // RV32E variant with a tiny counter so saturation is reachable quickly.
  decode_stage #(.XLEN(32), .NREGS(16), .CNT_W(3)) dut_e (
    .clk(clk), .nRst(nRst), .in_valid(in_valid), .in_ready(e_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(e_out_valid), .out_ready(out_ready),
    .out_pc(e_out_pc), .out_rs1(e_out_rs1), .out_rs2(e_out_rs2), .out_rd(e_out_rd),
    .out_cuOp(e_out_cuOp), .out_aluOp(e_out_aluOp), .out_regWrite(e_out_regWrite),
    .out_aluSrc(e_out_aluSrc), .out_isLoad(e_out_isLoad), .out_imm(e_out_imm),
    .out_illegal(e_out_illegal), .stall_cnt(e_stall_cnt)
  );

  typedef struct packed {
    logic [5:0]  cu;
    logic [3:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, src, ld, ill;
    logic [31:0] imm;
  } exp_t;

  // Instruction table: an encoding matches when (instr & mask) == match.
  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  cuop_t       t_cu[$];
  aluop_t      t_alu[$];

  task automatic add(input logic [31:0] m, input logic [31:0] v, input cuop_t c, input aluop_t a);
    t_mask.push_back(m); t_match.push_back(v); t_cu.push_back(c); t_alu.push_back(a);
  endtask

  task automatic init_table();
    add(32'h7F, 32'h37, CU_LUI, ALU_PASSB);     add(32'h7F, 32'h17, CU_AUIPC, ALU_ADD);
    add(32'h7F, 32'h6F, CU_JAL, ALU_ADD);       add(32'h707F, 32'h0067, CU_JALR, ALU_ADD);
    add(32'h707F, 32'h0063, CU_BEQ, ALU_SUB);   add(32'h707F, 32'h1063, CU_BNE, ALU_SUB);
    add(32'h707F, 32'h4063, CU_BLT, ALU_SLT);   add(32'h707F, 32'h5063, CU_BGE, ALU_SLT);
    add(32'h707F, 32'h6063, CU_BLTU, ALU_SLTU); add(32'h707F, 32'h7063, CU_BGEU, ALU_SLTU);
    add(32'h707F, 32'h0003, CU_LB, ALU_ADD);    add(32'h707F, 32'h1003, CU_LH, ALU_ADD);
    add(32'h707F, 32'h2003, CU_LW, ALU_ADD);    add(32'h707F, 32'h4003, CU_LBU, ALU_ADD);
    add(32'h707F, 32'h5003, CU_LHU, ALU_ADD);   add(32'h707F, 32'h0023, CU_SB, ALU_ADD);
    add(32'h707F, 32'h1023, CU_SH, ALU_ADD);    add(32'h707F, 32'h2023, CU_SW, ALU_ADD);
    add(32'h707F, 32'h0013, CU_ADDI, ALU_ADD);  add(32'h707F, 32'h2013, CU_SLTI, ALU_SLT);
    add(32'h707F, 32'h3013, CU_SLTIU, ALU_SLTU); add(32'h707F, 32'h4013, CU_XORI, ALU_XOR);
    add(32'h707F, 32'h6013, CU_ORI, ALU_OR);    add(32'h707F, 32'h7013, CU_ANDI, ALU_AND);
    add(32'hFE00707F, 32'h00001013, CU_SLLI, ALU_SLL);
    add(32'hFE00707F, 32'h00005013, CU_SRLI, ALU_SRL);
    add(32'hFE00707F, 32'h40005013, CU_SRAI, ALU_SRA);
    add(32'hFE00707F, 32'h00000033, CU_ADD, ALU_ADD);
    add(32'hFE00707F, 32'h40000033, CU_SUB, ALU_SUB);
    add(32'hFE00707F, 32'h00001033, CU_SLL, ALU_SLL);
    add(32'hFE00707F, 32'h00002033, CU_SLT, ALU_SLT);
    add(32'hFE00707F, 32'h00003033, CU_SLTU, ALU_SLTU);
    add(32'hFE00707F, 32'h00004033, CU_XOR, ALU_XOR);
    add(32'hFE00707F, 32'h00005033, CU_SRL, ALU_SRL);
    add(32'hFE00707F, 32'h40005033, CU_SRA, ALU_SRA);
    add(32'hFE00707F, 32'h00006033, CU_OR, ALU_OR);
    add(32'hFE00707F, 32'h00007033, CU_AND, ALU_AND);
  endtask

  function automatic logic m_uses_rs1(input logic [31:0] i);
    return !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic logic m_uses_rs2(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h63, 7'h23};
  endfunction

  function automatic exp_t model_decode(input logic [31:0] i, input int nregs);
    exp_t e;
    logic hit, wr, badreg;
    logic [6:0] op;
    op = i[6:0];
    hit = 1'b0;
    e = '0;
    for (int k = 0; k < t_mask.size(); k++) begin
      if ((i & t_mask[k]) == t_match[k]) begin
        hit = 1'b1; e.cu = t_cu[k]; e.alu = t_alu[k];
      end
    end
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    wr = !(op inside {7'h63, 7'h23});
    badreg = (wr && int'(i[11:7]) >= nregs) || (m_uses_rs1(i) && int'(i[19:15]) >= nregs) ||
             (m_uses_rs2(i) && int'(i[24:20]) >= nregs);
    e.ill = !hit || badreg;
    if (e.ill) begin
      e.cu = CU_ILLEGAL; e.alu = ALU_ADD; e.rw = 1'b0; e.src = 1'b0; e.ld = 1'b0; e.imm = '0;
    end else begin
      e.rw  = wr && (i[11:7] != 5'd0);
      e.src = !(op inside {7'h33, 7'h63});
      e.ld  = (op == 7'h03);
      case (op)
        7'h37, 7'h17: e.imm = {i[31:12], 12'h000};
        7'h6F: e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        7'h63: e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        7'h23: e.imm = 32'($signed({i[31:25], i[11:7]}));
        7'h33: e.imm = '0;
        default: e.imm = 32'($signed(i[31:20]));
      endcase
    end
    return e;
  endfunction

  // Mostly table-derived encodings with small register numbers so hazards happen often.
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    if ($urandom_range(0, 9) == 0) begin
      r = $urandom;
    end else begin
      k = $urandom_range(0, t_mask.size() - 1);
      r = t_match[k] | ($urandom & ~t_mask[k]);
    end
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    @(negedge clk); nRst = 1'b0;
    @(negedge clk); nRst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({out_valid, out_pc, out_rs1, out_rs2, out_rd, out_aluOp, out_regWrite, out_aluSrc,
         out_isLoad, out_imm, out_illegal} !== '0) begin
      bad++; $display("FAIL reset_fields: got valid=%b imm=%h pc=%h rd=%0d", out_valid, out_imm,
                      out_pc, out_rd);
    end
    total++;
    if (out_cuOp !== CU_NOP) begin bad++; $display("FAIL reset_cuop: got %0d want 0", out_cuOp); end
    total++;
    if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    do_reset();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_lui();
    do_reset();
    in_valid = 1'b1; in_instr = 32'hAAAAA537; in_pc = 32'h100; out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL lui_in_ready: got %b want 1", in_ready); end
    step(); in_valid = 1'b0;
    total++;
    if ({out_valid, out_cuOp, out_rd, out_imm, out_regWrite, out_aluSrc} !==
        {1'b1, CU_LUI, 5'd10, 32'hAAAAA000, 1'b1, 1'b1}) begin
      bad++; $display("FAIL lui_fields: got v=%b cu=%0d rd=%0d imm=%h rw=%b src=%b want 1 %0d 10 aaaaa000 1 1",
                      out_valid, out_cuOp, out_rd, out_imm, out_regWrite, out_aluSrc, CU_LUI);
    end
    total++;
    if (out_aluOp !== ALU_PASSB) begin bad++; $display("FAIL lui_aluop: got %0d want %0d", out_aluOp, ALU_PASSB); end
  endtask

  task automatic test_addi();
    do_reset();
    in_valid = 1'b1; in_instr = 32'hABC50D13; in_pc = 32'h200; out_ready = 1'b1;
    step(); in_valid = 1'b0;
    total++;
    if ({out_valid, out_cuOp, out_rd, out_rs1, out_imm, out_aluOp, out_aluSrc, out_pc} !==
        {1'b1, CU_ADDI, 5'd26, 5'd10, 32'hFFFFFABC, ALU_ADD, 1'b1, 32'h200}) begin
      bad++; $display("FAIL addi_fields: got v=%b cu=%0d rd=%0d rs1=%0d imm=%h alu=%0d src=%b pc=%h",
                      out_valid, out_cuOp, out_rd, out_rs1, out_imm, out_aluOp, out_aluSrc, out_pc);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_load_use();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hABCAA503; in_pc = 32'h300;
    step();
    in_instr = 32'h00C50C33; in_pc = 32'h304;
    @(negedge clk);
    total++;
    if ({out_valid, out_cuOp, in_ready} !== {1'b1, CU_LW, 1'b0}) begin
      bad++; $display("FAIL lu_stall: got v=%b cu=%0d rdy=%b want 1 %0d 0", out_valid, out_cuOp,
                      in_ready, CU_LW);
    end
    step();
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, stall_cnt} !== {1'b0, 1'b1, 16'd1}) begin
      bad++; $display("FAIL lu_bubble: got v=%b rdy=%b stall=%0d want 0 1 1", out_valid, in_ready,
                      stall_cnt);
    end
    step(); in_valid = 1'b0;
    total++;
    if ({out_valid, out_cuOp, out_rs1, out_pc, stall_cnt} !== {1'b1, CU_ADD, 5'd10, 32'h304, 16'd1}) begin
      bad++; $display("FAIL lu_second: got v=%b cu=%0d rs1=%0d pc=%h stall=%0d", out_valid, out_cuOp,
                      out_rs1, out_pc, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h40C50C33; in_pc = 32'h400;
    step();
    out_ready = 1'b0; in_instr = 32'hABC50D13; in_pc = 32'h404;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({in_ready, out_valid, out_cuOp, out_aluOp, out_pc} !== {1'b0, 1'b1, CU_SUB, ALU_SUB, 32'h400}) begin
        bad++; $display("FAIL bp_hold%0d: got rdy=%b v=%b cu=%0d alu=%0d pc=%h", c, in_ready, out_valid,
                        out_cuOp, out_aluOp, out_pc);
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", in_ready); end
    step(); in_valid = 1'b0;
    total++;
    if ({out_valid, out_cuOp, out_pc} !== {1'b1, CU_ADDI, 32'h404}) begin
      bad++; $display("FAIL bp_next: got v=%b cu=%0d pc=%h", out_valid, out_cuOp, out_pc);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_nodup: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hABC50D13; in_pc = 32'h500;
    step();
    out_ready = 1'b0; flush = 1'b1; in_instr = 32'hAAAAA537; in_pc = 32'h504;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    step(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty: got %b want 0", out_valid); end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F;
    step(); in_valid = 1'b0;
    total++;
    if ({out_valid, out_illegal, out_regWrite, out_cuOp} !== {1'b1, 1'b1, 1'b0, CU_ILLEGAL}) begin
      bad++; $display("FAIL illegal: got v=%b ill=%b rw=%b cu=%0d", out_valid, out_illegal,
                      out_regWrite, out_cuOp);
    end
  endtask

  task automatic test_rv32e();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00C50C33;
    step();
    total++;
    if ({e_out_valid, e_out_illegal, e_out_cuOp, e_out_regWrite, out_illegal} !==
        {1'b1, 1'b1, CU_ILLEGAL, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rv32e_bad_reg: got v=%b ill=%b cu=%0d rw=%b main_ill=%b", e_out_valid,
                      e_out_illegal, e_out_cuOp, e_out_regWrite, out_illegal);
    end
    in_instr = 32'h007302B3;
    step(); in_valid = 1'b0;
    total++;
    if ({e_out_illegal, e_out_cuOp, e_out_rd, e_out_rs1, e_out_rs2, e_out_regWrite} !==
        {1'b0, CU_ADD, 4'd5, 4'd6, 4'd7, 1'b1}) begin
      bad++; $display("FAIL rv32e_legal: got ill=%b cu=%0d rd=%0d rs1=%0d rs2=%0d rw=%b", e_out_illegal,
                      e_out_cuOp, e_out_rd, e_out_rs1, e_out_rs2, e_out_regWrite);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00012503; in_pc = 32'h600;
    step();
    in_instr = 32'h007502B3;
    for (int c = 0; c < 10; c++) step();
    total++;
    if ({in_ready, stall_cnt, e_stall_cnt} !== {1'b0, 16'd10, 3'd7}) begin
      bad++; $display("FAIL stall_sat: got rdy=%b stall=%0d e_stall=%0d want 0 10 7", in_ready,
                      stall_cnt, e_stall_cnt);
    end
    #2 nRst = 1'b0;
    #1;
    total++;
    if ({out_valid, out_pc, out_rs1, out_rs2, out_rd, out_cuOp, out_aluOp, out_regWrite, out_aluSrc,
         out_isLoad, out_imm, out_illegal, stall_cnt, e_out_valid, e_out_cuOp, e_stall_cnt} !== '0) begin
      bad++; $display("FAIL async_reset: got v=%b cu=%0d ld=%b stall=%0d e_v=%b e_stall=%0d", out_valid,
                      out_cuOp, out_isLoad, stall_cnt, e_out_valid, e_stall_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk); nRst = 1'b1;
    step();
  endtask

  task automatic test_random(input int n);
    logic        m_valid, hz, exp_ready;
    exp_t        m, d;
    logic [31:0] m_pc;
    int          m_stall;
    do_reset();
    m_valid = 1'b0; m = '0; m_pc = '0; m_stall = 0;
    for (int c = 0; c < n; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      @(negedge clk);
      d  = model_decode(in_instr, 32);
      hz = m_valid && m.ld && (m.rd != 5'd0) && in_valid &&
           ((m_uses_rs1(in_instr) && in_instr[19:15] == m.rd) ||
            (m_uses_rs2(in_instr) && in_instr[24:20] == m.rd));
      exp_ready = (!m_valid || out_ready) && !hz && !flush;
      total++;
      if (in_ready !== exp_ready) begin
        bad++; $display("FAIL rnd_ready c=%0d: got %b want %b instr=%h", c, in_ready, exp_ready, in_instr);
      end
      total++;
      if (out_valid !== m_valid) begin
        bad++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        total++;
        if ({out_cuOp, out_aluOp, out_rs1, out_rs2, out_rd, out_regWrite, out_aluSrc, out_isLoad,
             out_illegal, out_imm, out_pc} !==
            {m.cu, m.alu, m.rs1, m.rs2, m.rd, m.rw, m.src, m.ld, m.ill, m.imm, m_pc}) begin
          bad++; $display("FAIL rnd_fields c=%0d: got cu=%0d alu=%0d rd=%0d rw=%b src=%b ld=%b ill=%b imm=%h want cu=%0d alu=%0d rd=%0d rw=%b src=%b ld=%b ill=%b imm=%h",
                          c, out_cuOp, out_aluOp, out_rd, out_regWrite, out_aluSrc, out_isLoad,
                          out_illegal, out_imm, m.cu, m.alu, m.rd, m.rw, m.src, m.ld, m.ill, m.imm);
        end
      end
      total++;
      if (int'(stall_cnt) != m_stall) begin
        bad++; $display("FAIL rnd_stall c=%0d: got %0d want %0d", c, stall_cnt, m_stall);
      end
      if (in_valid && hz && !flush && m_stall < 65535) m_stall++;
      if (flush) m_valid = 1'b0;
      else if (in_valid && exp_ready) begin m_valid = 1'b1; m = d; m_pc = in_pc; end
      else if (m_valid && out_ready) m_valid = 1'b0;
      step();
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    init_table();
    test_reset();
    test_lui();
    test_addi();
    test_load_use();
    test_backpressure();
    test_flush();
    test_illegal();
    test_rv32e();
    test_reset_mid_stall();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked RV32I decode stage that replaces the purely combinational control unit. It sits between fetch and execute. It decodes each instruction into cuOp, aluOp, register indices, control bits and a fully sign-extended immediate, and holds the result in a one-entry output register. It also inserts a load-use bubble, supports flush, flags illegal encodings, and can be configured for RV32E (16 registers).

## Interface
Parameters:
- XLEN, 32: datapath width; width of the immediate and PC.
- NREGS, 32: architectural register count, 32 or 16. REG_W = $clog2(NREGS).
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- nRst  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of the instruction.
- flush  in  1  discard held and incoming instructions.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute consumes the instruction.
- out_pc  out  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  out  REG_W  register indices.
- out_cuOp  out  6  instruction class; cuop_t from control_pkg.
- out_aluOp  out  4  ALU function; aluop_t from control_pkg.
- out_regWrite  out  1  rd is written and rd != 0.
- out_aluSrc  out  1  ALU operand B is the immediate.
- out_isLoad  out  1  instruction is LB, LH, LW, LBU or LHU.
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J format).
- out_illegal  out  1  unknown opcode/funct, or a register index >= NREGS.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- hazard = out_valid & out_isLoad & (out_rd != 0) & in_valid & ((uses_rs1(in) & rs1(in) == out_rd) | (uses_rs2(in) & rs2(in) == out_rd)).
- uses_rs1 is false for LUI, AUIPC and JAL.
- uses_rs2 is true only for R-type, branches and stores.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Capture on in_valid & in_ready. The output register loads the decode of in_instr and state becomes FULL.
- Handoff on out_valid & out_ready with no capture: state becomes EMPTY.
- Capture and handoff in the same cycle: state stays FULL with the new contents.
- A dependent instruction is blocked only in the cycle the load leaves. This produces exactly one downstream bubble.
- Flush has priority over everything. The next state is EMPTY and the input offered in that cycle is dropped.
- Illegal instruction: out_illegal=1, out_cuOp=CU_ILLEGAL, out_regWrite=0. It still flows through the stage normally.
- For rd=0, regWrite=0, except for illegal instructions, where regWrite is also 0.
- stall_cnt increments in each cycle where in_valid & hazard & !flush holds. It saturates at all-ones and is never cleared except by reset.

## Timing
- Latency: instruction captured at edge t appears with out_valid=1 after edge t.
- Throughput: 1 instruction per cycle when out_ready=1 and there is no hazard.
- in_ready depends combinationally on in_valid, in_instr, out_ready and flush. Fetch must not make in_valid depend on in_ready.
- Output contents are stable while out_valid & !out_ready.
- Reset (asynchronous, at any time, including mid-stall): out_valid=0, all out_* fields=0, out_cuOp=CU_NOP (0), stall_cnt=0.
- Reset has no effect on parameters.

## Structure
- control_pkg holds:
  - cuop_t: 6-bit enum with CU_NOP=0, one code per RV32I instruction from LUI to AND, and CU_ILLEGAL.
  - aluop_t: 4-bit enum with ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - Opcode localparams.
  - Function uses_rs1/uses_rs2.
- Sub-module instr_decoder is purely combinational: instruction in, decoded fields out, parametrised by XLEN and NREGS.
- decode_stage contains the output register, hazard logic, flush handling and stall counter.

## Test plan
- LUI: 32'hAAAAA537 with out_ready=1 -> one cycle later out_cuOp=CU_LUI, out_rd=10, out_imm=32'hAAAAA000, regWrite=1, aluSrc=1.
- ADDI: 32'hABC50D13 -> rd=26, rs1=10, out_imm=32'hFFFFFABC, aluOp=ADD, aluSrc=1.
- Load-use: LW 32'hABCAA503 (rd=10) then ADD 32'h00C50C33 (rs1=10) offered back-to-back, out_ready=1 -> one in_ready=0 cycle, one out_valid=0 bubble between the two, stall_cnt=1.
- Backpressure: out_ready=0 for 3 cycles with SUB 32'h40C50C33 held -> in_ready=0, outputs stable, aluOp=SUB, no loss or duplication.
- Flush while FULL and in_valid=1 -> next cycle out_valid=0 and the offered instruction is never emitted.
- Illegal and RV32E:
  - 32'h0000007F -> out_illegal=1, regWrite=0.
  - With NREGS=16, ADD 32'h00C50C33 (rd=24) -> out_illegal=1.
  - Assert nRst low mid-stream -> all outputs 0 immediately.
